// File: rtl/cp0_exc_unit_if.sv
// Pipeline-side bundle for the CP0 / exception unit: memory-stage exception info,
// MTC0/MFC0 ports and the flush/redirect outputs.
interface cp0_exc_unit_if;
    logic        stall_i;
    logic        valid_i;
    logic [7:0]  except_i;
    logic [31:0] pc_i;
    logic        is_slot_i;
    logic [31:0] bad_addr_i;
    logic [5:0]  int_i;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic [4:0]  exc_code_o;
    logic        timer_int_o;

    modport master (
        output stall_i, valid_i, except_i, pc_i, is_slot_i, bad_addr_i, int_i,
               we_i, waddr_i, wdata_i, raddr_i,
        input  rdata_o, flush_o, new_pc_o, exc_code_o, timer_int_o
    );

    modport slave (
        input  stall_i, valid_i, except_i, pc_i, is_slot_i, bad_addr_i, int_i,
               we_i, waddr_i, wdata_i, raddr_i,
        output rdata_o, flush_o, new_pc_o, exc_code_o, timer_int_o
    );
endinterface

// File: rtl/cp0_exc_unit.sv
// CP0 register file plus precise-exception resolver for the memory stage.
// Resolution and flush/redirect are combinational; state updates at the clock edge.
module cp0_exc_unit #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input logic           clk,
    input logic           rst,
    cp0_exc_unit_if.slave bus
);
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] STATUS_BEV   = 32'h0040_0000;

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] status_q, status_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badv_q, badv_d;
    logic        tgl_q, tgl_d;
    logic        ti_q, ti_d;
    logic        bd_q, bd_d;
    logic [4:0]  code_q, code_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  ip_hw_q, ip_hw_d;

    logic        active;
    logic        int_pend;
    logic        exc_take;
    logic        eret_take;
    logic [4:0]  exc_code;
    logic [1:0]  bad_src;
    logic        wr_en;
    logic [31:0] cause_rd;
    logic [7:0]  ip_vec;
    logic        unused_bits;

    assign unused_bits = bus.int_i[5];

    assign ip_vec   = {ti_q, ip_hw_q, ip_sw_q};
    assign cause_rd = {bd_q, ti_q, 14'd0, ip_vec, 1'b0, code_q, 2'b00};
    assign active   = bus.valid_i && !bus.stall_i;
    assign int_pend = status_q[0] && !status_q[1] && ((ip_vec & status_q[15:8]) != 8'd0);

    // bad_src: 0 = no BadVAddr update, 1 = fetch PC, 2 = data address
    always_comb begin
        exc_take  = 1'b0;
        eret_take = 1'b0;
        exc_code  = 5'h00;
        bad_src   = 2'd0;
        if (active) begin
            if (int_pend) begin
                exc_take = 1'b1; exc_code = 5'h00;
            end else if (bus.except_i[7]) begin
                exc_take = 1'b1; exc_code = 5'h04; bad_src = 2'd1;
            end else if (bus.except_i[3]) begin
                exc_take = 1'b1; exc_code = 5'h0a;
            end else if (bus.except_i[2]) begin
                exc_take = 1'b1; exc_code = 5'h0c;
            end else if (bus.except_i[6]) begin
                exc_take = 1'b1; exc_code = 5'h08;
            end else if (bus.except_i[5]) begin
                exc_take = 1'b1; exc_code = 5'h09;
            end else if (bus.except_i[1]) begin
                exc_take = 1'b1; exc_code = 5'h04; bad_src = 2'd2;
            end else if (bus.except_i[0]) begin
                exc_take = 1'b1; exc_code = 5'h05; bad_src = 2'd2;
            end else if (bus.except_i[4]) begin
                eret_take = 1'b1;
            end
        end
    end

    assign wr_en = bus.we_i && active && !exc_take && !eret_take;

    always_comb begin
        count_d   = tgl_q ? count_q + 32'd1 : count_q;
        tgl_d     = ~tgl_q;
        compare_d = compare_q;
        status_d  = status_q;
        epc_d     = epc_q;
        badv_d    = badv_q;
        bd_d      = bd_q;
        code_d    = code_q;
        ip_sw_d   = ip_sw_q;
        ip_hw_d   = bus.int_i[4:0];
        ti_d      = ti_q || (count_q == compare_q);

        if (wr_en) begin
            case (bus.waddr_i)
                5'd9:  begin count_d = bus.wdata_i; tgl_d = 1'b0; end
                5'd11: begin compare_d = bus.wdata_i; ti_d = 1'b0; end
                5'd12: status_d = (bus.wdata_i & STATUS_WMASK) | STATUS_BEV;
                5'd13: ip_sw_d = bus.wdata_i[9:8];
                5'd14: epc_d = bus.wdata_i;
                default: ;
            endcase
        end

        if (exc_take) begin
            status_d[1] = 1'b1;
            code_d      = exc_code;
            // A nested exception keeps the original return point
            if (!status_q[1]) begin
                bd_d  = bus.is_slot_i;
                epc_d = bus.is_slot_i ? bus.pc_i - 32'd4 : bus.pc_i;
            end
            if (bad_src == 2'd1) badv_d = bus.pc_i;
            if (bad_src == 2'd2) badv_d = bus.bad_addr_i;
        end

        if (eret_take) status_d[1] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            status_q  <= STATUS_RST;
            epc_q     <= 32'd0;
            badv_q    <= 32'd0;
            tgl_q     <= 1'b0;
            ti_q      <= 1'b0;
            bd_q      <= 1'b0;
            code_q    <= 5'd0;
            ip_sw_q   <= 2'd0;
            ip_hw_q   <= 5'd0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            status_q  <= status_d;
            epc_q     <= epc_d;
            badv_q    <= badv_d;
            tgl_q     <= tgl_d;
            ti_q      <= ti_d;
            bd_q      <= bd_d;
            code_q    <= code_d;
            ip_sw_q   <= ip_sw_d;
            ip_hw_q   <= ip_hw_d;
        end
    end

    always_comb begin
        case (bus.raddr_i)
            5'd8:    bus.rdata_o = badv_q;
            5'd9:    bus.rdata_o = count_q;
            5'd11:   bus.rdata_o = compare_q;
            5'd12:   bus.rdata_o = status_q;
            5'd13:   bus.rdata_o = cause_rd;
            5'd14:   bus.rdata_o = epc_q;
            default: bus.rdata_o = 32'd0;
        endcase
        // Same-cycle MTC0 bypass, masked to the writable bits
        if (bus.we_i && (bus.waddr_i == bus.raddr_i)) begin
            case (bus.waddr_i)
                5'd9, 5'd11, 5'd14: bus.rdata_o = bus.wdata_i;
                5'd12:   bus.rdata_o = (bus.wdata_i & STATUS_WMASK) | STATUS_BEV;
                5'd13:   bus.rdata_o = {cause_rd[31:10], bus.wdata_i[9:8], cause_rd[7:0]};
                default: ;
            endcase
        end
    end

    assign bus.flush_o     = rst && (exc_take || eret_take);
    assign bus.new_pc_o    = !rst ? 32'd0 :
                             exc_take ? EXC_VECTOR :
                             eret_take ? epc_q : 32'd0;
    assign bus.exc_code_o  = code_q;
    assign bus.timer_int_o = ti_q;
endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed self-checking bench for cp0_exc_unit.
module tb_cp0_exc_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    cp0_exc_unit_if bus ();

    cp0_exc_unit #(
        .EXC_VECTOR(32'hBFC0_0380),
        .STATUS_RST(32'h0040_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.stall_i    = 1'b0;
        bus.valid_i    = 1'b0;
        bus.except_i   = 8'h00;
        bus.pc_i       = 32'd0;
        bus.is_slot_i  = 1'b0;
        bus.bad_addr_i = 32'd0;
        bus.int_i      = 6'd0;
        bus.we_i       = 1'b0;
        bus.waddr_i    = 5'd0;
        bus.wdata_i    = 32'd0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        idle();
        bus.valid_i = 1'b1;
        bus.we_i    = 1'b1;
        bus.waddr_i = a;
        bus.wdata_i = d;
        tick();
        idle();
    endtask

    task automatic test_reset;
        idle();
        bus.raddr_i = 5'd12;
        rst = 1'b0;
        tick();
        tick();
        #1;
        total++; if (bus.rdata_o !== 32'h0040_0000) begin bad++; $display("FAIL reset_status got=%h exp=%h", bus.rdata_o, 32'h0040_0000); end
        total++; if (bus.flush_o !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b exp=0", bus.flush_o); end
        total++; if (bus.timer_int_o !== 1'b0) begin bad++; $display("FAIL reset_ti got=%b exp=0", bus.timer_int_o); end
        total++; if (bus.exc_code_o !== 5'd0) begin bad++; $display("FAIL reset_code got=%h exp=0", bus.exc_code_o); end
        bus.raddr_i = 5'd9;
        #1;
        total++; if (bus.rdata_o !== 32'd0) begin bad++; $display("FAIL reset_count got=%h exp=0", bus.rdata_o); end
        rst = 1'b1;
        tick();
        tick();
        total++; if (bus.rdata_o !== 32'd1) begin bad++; $display("FAIL count_2clk got=%h exp=1", bus.rdata_o); end
        repeat (8) tick();
        total++; if (bus.rdata_o !== 32'd5) begin bad++; $display("FAIL count_10clk got=%h exp=5", bus.rdata_o); end
    endtask

    task automatic test_syscall;
        idle();
        bus.valid_i  = 1'b1;
        bus.except_i = 8'h40;
        bus.pc_i     = 32'hBFC0_0100;
        #1;
        total++; if (bus.flush_o !== 1'b1) begin bad++; $display("FAIL sys_flush got=%b exp=1", bus.flush_o); end
        total++; if (bus.new_pc_o !== 32'hBFC0_0380) begin bad++; $display("FAIL sys_newpc got=%h exp=bfc00380", bus.new_pc_o); end
        tick();
        idle();
        bus.raddr_i = 5'd14;
        #1;
        total++; if (bus.rdata_o !== 32'hBFC0_0100) begin bad++; $display("FAIL sys_epc got=%h exp=bfc00100", bus.rdata_o); end
        bus.raddr_i = 5'd13;
        #1;
        total++; if (bus.rdata_o[6:2] !== 5'h08) begin bad++; $display("FAIL sys_cause_code got=%h exp=08", bus.rdata_o[6:2]); end
        bus.raddr_i = 5'd12;
        #1;
        total++; if (bus.rdata_o[1] !== 1'b1) begin bad++; $display("FAIL sys_exl got=%b exp=1", bus.rdata_o[1]); end
        total++; if (bus.flush_o !== 1'b0) begin bad++; $display("FAIL idle_flush got=%b exp=0", bus.flush_o); end
    endtask

    task automatic test_mtc0_bypass;
        idle();
        bus.raddr_i = 5'd12;
        bus.valid_i = 1'b1;
        bus.we_i    = 1'b1;
        bus.waddr_i = 5'd12;
        bus.wdata_i = 32'hFFFF_FFFF;
        #1;
        total++; if (bus.rdata_o !== 32'h0040_FF03) begin bad++; $display("FAIL bypass_status got=%h exp=0040ff03", bus.rdata_o); end
        bus.wdata_i = 32'd0;
        tick();
        idle();
        #1;
        total++; if (bus.rdata_o !== 32'h0040_0000) begin bad++; $display("FAIL status_clear got=%h exp=00400000", bus.rdata_o); end
    endtask

    task automatic test_delay_slot;
        idle();
        bus.valid_i   = 1'b1;
        bus.except_i  = 8'h04;
        bus.pc_i      = 32'h8000_0010;
        bus.is_slot_i = 1'b1;
        bus.we_i      = 1'b1;
        bus.waddr_i   = 5'd11;
        bus.wdata_i   = 32'h0000_1234;
        tick();
        idle();
        bus.raddr_i = 5'd14;
        #1;
        total++; if (bus.rdata_o !== 32'h8000_000C) begin bad++; $display("FAIL ov_epc got=%h exp=8000000c", bus.rdata_o); end
        bus.raddr_i = 5'd13;
        #1;
        total++; if (bus.rdata_o[31] !== 1'b1) begin bad++; $display("FAIL ov_bd got=%b exp=1", bus.rdata_o[31]); end
        total++; if (bus.exc_code_o !== 5'h0c) begin bad++; $display("FAIL ov_code got=%h exp=0c", bus.exc_code_o); end
        bus.raddr_i = 5'd11;
        #1;
        total++; if (bus.rdata_o !== 32'd0) begin bad++; $display("FAIL ov_mtc0_cancel got=%h exp=0", bus.rdata_o); end
        // Nested exception while EXL=1 keeps EPC and BD
        bus.valid_i  = 1'b1;
        bus.except_i = 8'h40;
        bus.pc_i     = 32'h9000_0000;
        tick();
        idle();
        bus.raddr_i = 5'd14;
        #1;
        total++; if (bus.rdata_o !== 32'h8000_000C) begin bad++; $display("FAIL nested_epc got=%h exp=8000000c", bus.rdata_o); end
        bus.raddr_i = 5'd13;
        #1;
        total++; if (bus.rdata_o[31] !== 1'b1) begin bad++; $display("FAIL nested_bd got=%b exp=1", bus.rdata_o[31]); end
        total++; if (bus.exc_code_o !== 5'h08) begin bad++; $display("FAIL nested_code got=%h exp=08", bus.exc_code_o); end
    endtask

    task automatic test_ades;
        idle();
        bus.valid_i    = 1'b1;
        bus.except_i   = 8'h01;
        bus.pc_i       = 32'h8000_0100;
        bus.bad_addr_i = 32'h8000_0003;
        tick();
        idle();
        bus.raddr_i = 5'd8;
        #1;
        total++; if (bus.rdata_o !== 32'h8000_0003) begin bad++; $display("FAIL ades_badv got=%h exp=80000003", bus.rdata_o); end
        total++; if (bus.exc_code_o !== 5'h05) begin bad++; $display("FAIL ades_code got=%h exp=05", bus.exc_code_o); end
        bus.valid_i    = 1'b1;
        bus.except_i   = 8'h81;
        bus.pc_i       = 32'h8000_0200;
        bus.bad_addr_i = 32'h8000_0003;
        tick();
        idle();
        #1;
        total++; if (bus.rdata_o !== 32'h8000_0200) begin bad++; $display("FAIL adel_fetch_badv got=%h exp=80000200", bus.rdata_o); end
        total++; if (bus.exc_code_o !== 5'h04) begin bad++; $display("FAIL adel_fetch_code got=%h exp=04", bus.exc_code_o); end
    endtask

    task automatic test_eret;
        mtc0(5'd14, 32'h8000_0040);
        bus.valid_i  = 1'b1;
        bus.except_i = 8'h10;
        #1;
        total++; if (bus.flush_o !== 1'b1) begin bad++; $display("FAIL eret_flush got=%b exp=1", bus.flush_o); end
        total++; if (bus.new_pc_o !== 32'h8000_0040) begin bad++; $display("FAIL eret_newpc got=%h exp=80000040", bus.new_pc_o); end
        tick();
        idle();
        bus.raddr_i = 5'd12;
        #1;
        total++; if (bus.rdata_o[1] !== 1'b0) begin bad++; $display("FAIL eret_exl got=%b exp=0", bus.rdata_o[1]); end
        // RI outranks Eret
        bus.valid_i  = 1'b1;
        bus.except_i = 8'h18;
        bus.pc_i     = 32'h8000_0300;
        #1;
        total++; if (bus.new_pc_o !== 32'hBFC0_0380) begin bad++; $display("FAIL ri_eret_newpc got=%h exp=bfc00380", bus.new_pc_o); end
        tick();
        idle();
        #1;
        total++; if (bus.exc_code_o !== 5'h0a) begin bad++; $display("FAIL ri_code got=%h exp=0a", bus.exc_code_o); end
    endtask

    task automatic test_timer;
        int  n;
        logic hit;
        mtc0(5'd9, 32'd0);
        mtc0(5'd11, 32'd6);
        mtc0(5'd12, 32'h0000_8001);
        bus.raddr_i = 5'd9;
        hit = 1'b0;
        n = 0;
        #1;
        while (!hit && n < 60) begin
            if (bus.rdata_o == 32'd6) hit = 1'b1;
            else begin tick(); n++; end
        end
        total++; if (!hit) begin bad++; $display("FAIL timer_reach got=%h exp=6", bus.rdata_o); end
        tick();
        total++; if (bus.timer_int_o !== 1'b1) begin bad++; $display("FAIL timer_ti got=%b exp=1", bus.timer_int_o); end
        bus.raddr_i = 5'd13;
        #1;
        total++; if (bus.rdata_o[30] !== 1'b1 || bus.rdata_o[15] !== 1'b1) begin bad++; $display("FAIL timer_cause got=%h exp_bits30_15=1", bus.rdata_o); end
        bus.valid_i = 1'b1;
        bus.stall_i = 1'b1;
        #1;
        total++; if (bus.flush_o !== 1'b0) begin bad++; $display("FAIL stall_flush got=%b exp=0", bus.flush_o); end
        tick();
        bus.raddr_i = 5'd12;
        #1;
        total++; if (bus.rdata_o !== 32'h0040_8001) begin bad++; $display("FAIL stall_status got=%h exp=00408001", bus.rdata_o); end
        bus.stall_i = 1'b0;
        #1;
        total++; if (bus.flush_o !== 1'b1 || bus.new_pc_o !== 32'hBFC0_0380) begin bad++; $display("FAIL int_flush got=%b/%h exp=1/bfc00380", bus.flush_o, bus.new_pc_o); end
        tick();
        idle();
        #1;
        total++; if (bus.exc_code_o !== 5'h00) begin bad++; $display("FAIL int_code got=%h exp=00", bus.exc_code_o); end
        total++; if (bus.rdata_o !== 32'h0040_8003) begin bad++; $display("FAIL int_status got=%h exp=00408003", bus.rdata_o); end
        mtc0(5'd11, 32'd100);
        total++; if (bus.timer_int_o !== 1'b0) begin bad++; $display("FAIL ti_clear got=%b exp=0", bus.timer_int_o); end
    endtask

    initial begin
        bus.raddr_i = 5'd0;
        idle();
        test_reset();
        test_syscall();
        test_mtc0_bypass();
        test_delay_slot();
        test_ades();
        test_eret();
        test_timer();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cp0_exc_unit.md
Name: cp0_exc_unit

Overview:
- Coprocessor-0 register file and precise-exception controller.
- Sits beside the memory stage of the 5-stage MIPS pipeline.
- Consumes the per-instruction exception vector, PC and delay-slot flag carried down to the memory stage, and resolves one exception or ERET per cycle.
- Drives a pipeline flush plus redirect PC; provides the MFC0 read port (decode) and MTC0 write port (memory stage).

Parameters:
- EXC_VECTOR, 32'hBFC0_0380, redirect target for every exception/interrupt.
- STATUS_RST, 32'h0040_0000, Status reset value (BEV=1).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- stall_i  in  1  memory stage stalled; no commit, no flush this cycle
- valid_i  in  1  memory stage holds a real (non-bubble) instruction
- except_i  in  8  [7]AdEL-fetch [6]Syscall [5]Break [4]Eret [3]RI [2]Ov [1]AdEL-data [0]AdES-data
- pc_i  in  32  memory-stage instruction PC
- is_slot_i  in  1  instruction is in a branch delay slot
- bad_addr_i  in  32  data address of memory-stage load/store
- int_i  in  6  hardware interrupt lines
- we_i  in  1  MTC0 write enable (memory stage)
- waddr_i  in  5  MTC0 register number
- wdata_i  in  32  MTC0 data
- raddr_i  in  5  MFC0 register number (decode)
- rdata_o  out  32  MFC0 read data
- flush_o  out  1  flush all pipeline stages
- new_pc_o  out  32  redirect PC, valid when flush_o=1
- exc_code_o  out  5  resolved ExcCode (debug/trace)
- timer_int_o  out  1  Cause.TI

Behaviour:
- Reset: one clock, synchronous, active-low: rst=0 sampled at a clk rising edge resets all state.
- Reset values:
  - Status=STATUS_RST; Cause, EPC, BadVAddr, Count, Compare = 0; count toggle = 0.
  - flush_o=0, new_pc_o=0, exc_code_o=0, timer_int_o=0.
- Implemented registers: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC. All other numbers read 0; writes to them are ignored.
- Writable bits:
  - Status: IM[15:8], EXL[1], IE[0]; BEV[22] reads constant 1; all other bits read 0.
  - Cause: IP[9:8] only.
  - Count, Compare, EPC: full 32 bits.
  - BadVAddr: read-only to software.
- Read port: combinational. If we_i=1 and waddr_i=raddr_i, rdata_o returns the value being written, masked to the writable bits (same-cycle bypass).
- Count: increments by 1 every second clock (internal toggle); wraps 0xFFFF_FFFF to 0. An MTC0 to Count overrides the increment that cycle and resets the toggle.
- Timer: Cause.TI[30] and IP7[15] set when Count==Compare. Cleared by an MTC0 to Compare, which takes priority over setting in the same cycle. Cause.IP[14:10] = int_i[4:0], sampled every clock.
- Interrupt pending: Status.IE=1, Status.EXL=0, and (Cause.IP[15:8] & Status.IM)!=0.
- Resolution is combinational and only when valid_i=1 and stall_i=0. Priority, highest first:
  - Int 0x00, AdEL-fetch 0x04, RI 0x0a, Ov 0x0c, Sys 0x08, Bp 0x09, AdEL-data 0x04, AdES-data 0x05, then Eret.
- On an exception (not Eret):
  - flush_o=1, new_pc_o=EXC_VECTOR.
  - At the clock edge: EXL<=1; Cause.BD<=is_slot_i; Cause.ExcCode<=code.
  - If EXL was 0, EPC <= is_slot_i ? pc_i-4 : pc_i. If EXL was already 1, EPC and BD are left unchanged.
  - BadVAddr<=pc_i for AdEL-fetch; BadVAddr<=bad_addr_i for AdEL/AdES-data.
- On Eret (no higher exception): flush_o=1, new_pc_o=EPC (current register value); EXL<=0 at the edge.
- If an exception or Eret is taken in a cycle, a concurrent MTC0 is suppressed (the instruction is cancelled).
- stall_i=1 or valid_i=0: flush_o=0, no architectural update except Count/timer/IP sampling.
- exc_code_o holds the last taken code; it is unchanged when nothing is taken.

Test Plan:
- Reset: hold rst=0 for 2 cycles -> rdata_o(raddr=12)=0x0040_0000, flush_o=0, Count=0. Release -> Count=1 after 2 clocks, 5 after 10.
- Syscall: valid=1, except_i=8'h40, pc_i=0xBFC0_0100, is_slot=0 -> flush_o=1, new_pc_o=0xBFC0_0380. Next cycle EPC=0xBFC0_0100, Cause[6:2]=0x08, Status.EXL=1.
- Delay-slot overflow: except_i=8'h04, pc_i=0x8000_0010, is_slot=1 -> EPC=0x8000_000C, Cause.BD=1, code 0x0C. A same-cycle MTC0 to Compare is not applied.
- AdES: except_i=8'h01, bad_addr_i=0x8000_0003 -> BadVAddr=0x8000_0003, code 0x05. Repeat with except_i=8'h81 -> AdEL-fetch wins, BadVAddr=pc_i.
- Eret: EPC=0x8000_0040, EXL=1, except_i=8'h10 -> flush_o=1, new_pc_o=0x8000_0040, EXL=0 next cycle.
- Timer interrupt: write Compare=6, Status=0x0000_8001; wait until Count=6 -> TI=1; next valid unstalled instruction flushes with code 0x00. MTC0 Compare clears TI. With stall_i=1 the interrupt is not taken.
